cram_ld_seq: RTL

Load sequencer for the on-chip CRAM, the read-side counterpart of the store sequencer.
- Accepts an acquire token followed by a config/length/stride/base word stream on I_FTk.
- Generates CRAM read addresses and returns the read words downstream as FTk_t tokens, honouring nack back-pressure.
- Closes the sequence with a release token and a terminate back-token.
- Sits between the CRAM read port and the compute fabric, one instance per CRAM port.

---
 rtl/cram_ld_seq_pkg.sv | 51 +++++
 rtl/cram_ld_seq_skid.sv | 47 ++++
 rtl/cram_ld_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cram_ld_seq_pkg.sv
// Shared types for the CRAM load sequencer: token structs, token decode,
// FSM state encoding and config-word field positions.
package cram_ld_seq_pkg;

  localparam int unsigned FTK_DATA_W = 32;

  // Forward token: valid, acquire, release, continue, data
  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic                  c;
    logic [FTK_DATA_W-1:0] d;
  } FTk_t;

  // Back token: nack/busy, terminate
  typedef struct packed {
    logic n;
    logic t;
  } BTk_t;

  typedef enum logic [1:0] {
    TOK_DATA,
    TOK_ACQUIRE,
    TOK_RELEASE
  } tok_kind_t;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    LEN,
    STR,
    BASE,
    RUN,
    DRAIN,
    RLS
  } cram_ld_state_t;

  // Config word field positions
  localparam int unsigned CFG_DEC_BIT   = 0;
  localparam int unsigned CFG_SHARE_BIT = 1;
  localparam int unsigned CFG_MODE_LSB  = 2;

  // Classify a forward token by its acquire/release flags
  function automatic tok_kind_t TokenDec(input FTk_t tk);
    if (tk.a && tk.r) return TOK_RELEASE;
    else if (tk.a)    return TOK_ACQUIRE;
    else              return TOK_DATA;
  endfunction

endpackage

// File: rtl/cram_ld_seq_skid.sv
// Small circular FIFO that absorbs CRAM read data while downstream nacks.
module cram_ld_seq_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_pop;

  assign empty    = (occupancy == '0);
  assign full     = (occupancy == OW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      if (push && !do_pop)      occupancy <= occupancy + OW'(1);
      else if (!push && do_pop) occupancy <= occupancy - OW'(1);
    end
  end

endmodule

// File: rtl/cram_ld_seq.sv
// CRAM load sequencer: takes acquire/config/length/stride/base tokens,
// issues strided CRAM reads and streams the data out, ending with release.
module cram_ld_seq
  import cram_ld_seq_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned WIDTH_ADDR = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned DEPTH_SKID = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  FTk_t                  I_FTk,
  output BTk_t                  O_BTk,
  output logic                  O_Ld_Req,
  output logic [WIDTH_ADDR-1:0] O_Ld_Addr,
  input  logic [WIDTH_DATA-1:0] I_Ld_Data,
  output FTk_t                  O_FTk,
  input  BTk_t                  I_BTk,
  output logic [1:0]            O_Mode,
  output logic                  O_AccessEnd,
  output logic                  O_Busy
);

  localparam int unsigned OW = $clog2(DEPTH_SKID+1);

  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("cram_ld_seq: only RD_LATENCY == 1 is supported");
  end
  if (DEPTH_SKID < RD_LATENCY + 1) begin : g_bad_depth
    $error("cram_ld_seq: DEPTH_SKID must be at least RD_LATENCY+1");
  end
  if (WIDTH_DATA != FTK_DATA_W) begin : g_bad_width
    $error("cram_ld_seq: WIDTH_DATA must match FTk_t data width");
  end

  cram_ld_state_t state_q, state_d;

  logic                  dec_q, share_q, inflight_q;
  logic [1:0]            mode_q;
  logic [WIDTH_ADDR-1:0] stride_q, addr_q;
  logic [WIDTH_ADDR:0]   count_q;

  logic cap_cfg, cap_len, cap_str, cap_base, clear_cfg;
  logic issue, last_issue, pop;
  logic [OW:0] pending;
  tok_kind_t in_kind;

  logic [WIDTH_DATA-1:0] skid_data;
  logic [OW-1:0]         skid_occ;
  logic                  skid_empty, skid_full;

  cram_ld_seq_skid #(
    .WIDTH (WIDTH_DATA),
    .DEPTH (DEPTH_SKID)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (I_Ld_Data),
    .pop       (pop),
    .pop_data  (skid_data),
    .occupancy (skid_occ),
    .empty     (skid_empty),
    .full      (skid_full)
  );

  assign in_kind    = TokenDec(I_FTk);
  assign pending    = {1'b0, skid_occ} + (OW+1)'(inflight_q);
  assign issue      = (state_q == RUN) && (count_q != '0) && (pending < (OW+1)'(DEPTH_SKID));
  assign last_issue = issue && (count_q == (WIDTH_ADDR+1)'(1));
  assign pop        = !skid_empty && !I_BTk.n;

  assign O_Ld_Req    = issue;
  assign O_Ld_Addr   = addr_q;
  assign O_AccessEnd = last_issue;
  assign O_Mode      = mode_q;
  assign O_Busy      = (state_q != IDLE);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, capture strobes and token outputs
  always_comb begin
    state_d   = state_q;
    cap_cfg   = 1'b0;
    cap_len   = 1'b0;
    cap_str   = 1'b0;
    cap_base  = 1'b0;
    clear_cfg = 1'b0;
    O_BTk     = '0;
    O_FTk     = '0;
    O_FTk.v   = !skid_empty;
    O_FTk.d   = skid_empty ? '0 : skid_data;

    case (state_q)
      IDLE: if (I_FTk.v && in_kind == TOK_ACQUIRE) state_d = CFG;
      CFG, LEN, STR, BASE: begin
        if (I_FTk.v) begin
          if (in_kind == TOK_RELEASE) begin
            clear_cfg = 1'b1;
            state_d   = IDLE;
          end else begin
            case (state_q)
              CFG:     begin cap_cfg  = 1'b1; state_d = LEN;  end
              LEN:     begin cap_len  = 1'b1; state_d = STR;  end
              STR:     begin cap_str  = 1'b1; state_d = BASE; end
              default: begin cap_base = 1'b1; state_d = RUN;  end
            endcase
          end
        end
      end
      RUN: begin
        O_BTk.n = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        O_BTk.n = 1'b1;
        if (!inflight_q && skid_empty) state_d = RLS;
      end
      RLS: begin
        O_BTk.n = 1'b1;
        O_FTk.v = 1'b1;
        O_FTk.a = 1'b1;
        O_FTk.r = 1'b1;
        O_FTk.d = '0;
        if (!I_BTk.n) begin
          O_BTk.t   = 1'b1;
          clear_cfg = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured config, length counter, address generator and read-in-flight flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_q      <= 1'b0;
      share_q    <= 1'b0;
      mode_q     <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (clear_cfg) begin
        dec_q    <= 1'b0;
        share_q  <= 1'b0;
        mode_q   <= '0;
        stride_q <= '0;
        addr_q   <= '0;
        count_q  <= '0;
      end
      if (cap_cfg) begin
        dec_q   <= I_FTk.d[CFG_DEC_BIT];
        share_q <= I_FTk.d[CFG_SHARE_BIT];
        mode_q  <= I_FTk.d[CFG_MODE_LSB +: 2];
      end
      if (cap_len)
        count_q <= {1'b0, I_FTk.d[WIDTH_ADDR-1:0]} + (WIDTH_ADDR+1)'(share_q)
                   + (WIDTH_ADDR+1)'(1);
      if (cap_str)  stride_q <= I_FTk.d[WIDTH_ADDR-1:0];
      if (cap_base) addr_q   <= I_FTk.d[WIDTH_ADDR-1:0];
      if (issue) begin
        count_q <= count_q - (WIDTH_ADDR+1)'(1);
        addr_q  <= dec_q ? addr_q - stride_q : addr_q + stride_q;
      end
    end
  end

  logic unused_skid_full;
  assign unused_skid_full = skid_full;

endmodule
